// File: rtl/sw_mux_pkg.sv
// ============================================================================
// Module      : sw_mux_pkg
// Description : Shared types and helpers for the switch/LED channel scanner.
//               Holds the selector FSM state encoding, the io_mode encodings
//               and the round-robin next-channel helper.
// Ports       : none (package)
// Options     : none
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sw_mux_pkg;

  // Selector FSM states. Freeze outranks mode when the next state is decoded.
  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    SCAN   = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // io_mode encodings
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Round-robin successor of channel cur among ch channels (ch-1 wraps to 0).
  function automatic int unsigned next_chan(input int unsigned cur,
                                            input int unsigned ch);
    return (cur == ch - 32'd1) ? 32'd0 : cur + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sw_debounce.sv
// ============================================================================
// Module      : sw_debounce
// Description : Single registered bus debouncer. A candidate register follows
//               the input; any change reloads it and clears the stability
//               counter. Once the candidate has been held for CYC consecutive
//               sampled cycles it is copied to the output.
// Ports       : clock  in  1      system clock
//               reset  in  1      asynchronous active-high reset
//               din    in  WIDTH  raw bus
//               dout   out WIDTH  debounced bus (registered)
// Options     : instantiated by sw_mux_scanner only with SW_MUX_DEBOUNCE_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_debounce #(
  parameter int WIDTH = 1,
  parameter int CYC   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int               CNT_W  = (CYC > 2) ? $clog2(CYC) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(CYC - 1);

  logic [WIDTH-1:0] r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_out;

  // The adopt test looks only at the counter, not at the current input: a
  // value sampled on CYC consecutive edges is accepted even if the input
  // moves away on the very edge where the count completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cand <= '0;
      r_cnt  <= '0;
      r_out  <= '0;
    end else begin
      if (r_cnt == c_last) begin
        r_out <= r_cand;
      end
      if (din != r_cand) begin
        r_cand <= din;
        r_cnt  <= '0;
      end else if (r_cnt != c_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign dout = r_out;

endmodule

`default_nettype wire

// File: rtl/sw_mux_scanner.sv
// ============================================================================
// Module      : sw_mux_scanner
// Description : N-channel, W-bit registered channel selector for switch banks
//               driving LEDs. Manual select or round-robin auto-scan with a
//               fixed dwell; freeze holds the displayed channel and data.
// Ports       : clock        in  1      system clock
//               reset        in  1      asynchronous active-high reset
//               io_in        in  CH*W   packed channels, ch k = io_in[k*W +: W]
//               io_select    in  SEL_W  manual channel select
//               io_mode      in  1      0 = manual, 1 = auto-scan
//               io_freeze    in  1      1 = hold io_out / io_cur_sel
//               io_out       out W      registered selected channel data
//               io_cur_sel   out SEL_W  channel currently driving io_out
//               io_switched  out 1      one-cycle pulse after a channel change
// Options     : SW_MUX_DEBOUNCE_EN - debounce io_select over DB_CYC cycles
//               (default: io_select passes through a single register stage)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_mux_scanner
  import sw_mux_pkg::*;
#(
  parameter  int CH     = 4,
  parameter  int W      = 2,
  parameter  int DWELL  = 1000,
  parameter  int DB_CYC = 16,
  localparam int SEL_W  = $clog2(CH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [CH*W-1:0] io_in,
  input  logic [SEL_W-1:0] io_select,
  input  logic            io_mode,
  input  logic            io_freeze,
  output logic [W-1:0]    io_out,
  output logic [SEL_W-1:0] io_cur_sel,
  output logic            io_switched
);

  localparam int               CNT_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(DWELL - 1);

  if (CH < 2 || W < 1 || DWELL < 1 || DB_CYC < 2) begin : g_param_check
    $error("sw_mux_scanner: illegal parameter combination");
  end

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_dwell, w_dwell_nxt;
  logic [SEL_W-1:0] r_cur_sel, w_sel_nxt;
  logic [SEL_W-1:0] r_prev_sel;
  logic [W-1:0]     r_out, w_out_nxt;
  logic             r_switched, w_switched_nxt;
  logic [SEL_W-1:0] w_sel_eff;
  logic [W-1:0]     w_chan;
  logic             w_sel_ok;

  // ---- effective manual select ---------------------------------------------
`ifdef SW_MUX_DEBOUNCE_EN
  sw_debounce #(
    .WIDTH (SEL_W),
    .CYC   (DB_CYC)
  ) u_debounce (
    .clock (clock),
    .reset (reset),
    .din   (io_select),
    .dout  (w_sel_eff)
  );
`else
  logic [SEL_W-1:0] r_sel;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_sel <= '0;
    else       r_sel <= io_select;
  end

  assign w_sel_eff = r_sel;
`endif

  // One extra bit keeps the range test meaningful when CH is a power of two.
  assign w_sel_ok = ({1'b0, w_sel_eff} < (SEL_W + 1)'(CH));

  // Packed-input slice mux
  assign w_chan = io_in[32'(r_cur_sel) * W +: W];

  // ---- FSM state register --------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= MANUAL;
    else       r_state <= w_state_nxt;
  end

  // ---- next state / datapath decode ----------------------------------------
  // Actions follow the freshly decoded state, so freeze and mode take effect
  // on the same edge that samples them.
  always_comb begin
    w_state_nxt    = MANUAL;
    w_dwell_nxt    = r_dwell;
    w_sel_nxt      = r_cur_sel;
    w_out_nxt      = r_out;
    w_switched_nxt = 1'b0;

    if (io_freeze)                   w_state_nxt = HOLD;
    else if (io_mode == MODE_SCAN)   w_state_nxt = SCAN;
    else                             w_state_nxt = MANUAL;

    case (w_state_nxt)
      MANUAL: begin
        w_dwell_nxt = '0;
        if (w_sel_ok) w_sel_nxt = w_sel_eff;
        w_out_nxt = w_chan;
      end
      SCAN: begin
        // Entry (from MANUAL or HOLD) restarts a full dwell on the current
        // channel; a partial dwell is never carried across a mode change.
        if (r_state != SCAN) begin
          w_dwell_nxt = '0;
        end else if (r_dwell == c_last) begin
          w_dwell_nxt = '0;
          w_sel_nxt   = SEL_W'(next_chan(32'(r_cur_sel), CH));
        end else begin
          w_dwell_nxt = r_dwell + CNT_W'(1);
        end
        w_out_nxt = w_chan;
      end
      default: begin
        // HOLD: everything stays put
      end
    endcase

    // r_prev_sel lags r_cur_sel by one edge, so the pulse lands together
    // with the first io_out sample of the new channel.
    w_switched_nxt = (w_state_nxt != HOLD) && (r_prev_sel != r_cur_sel);
  end

  // ---- datapath registers --------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dwell    <= '0;
      r_cur_sel  <= '0;
      r_prev_sel <= '0;
      r_out      <= '0;
      r_switched <= 1'b0;
    end else begin
      r_dwell    <= w_dwell_nxt;
      r_cur_sel  <= w_sel_nxt;
      r_prev_sel <= r_cur_sel;
      r_out      <= w_out_nxt;
      r_switched <= w_switched_nxt;
    end
  end

  assign io_out      = r_out;
  assign io_cur_sel  = r_cur_sel;
  assign io_switched = r_switched;

endmodule

`default_nettype wire

// File: tb/tb_sw_mux_scanner.sv
// ============================================================================
// Module      : tb_sw_mux_scanner
// Description : Self-checking bench for sw_mux_scanner. Expected values are
//               queued with a due cycle when stimulus is driven and compared
//               on the falling edge of that cycle. A second instance with
//               CH=3 covers the out-of-range select case.
// Options     : SW_MUX_DEBOUNCE_EN - adds the debounce glitch/adopt cases
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sw_mux_scanner;

  localparam int DB_CYC = 3;
`ifdef SW_MUX_DEBOUNCE_EN
  localparam int L = DB_CYC + 2;   // select change -> io_cur_sel
`else
  localparam int L = 2;
`endif

  localparam int K_OUT = 0, K_SEL = 1, K_SW = 2, K_SEL3 = 3, K_SW3 = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] io_in;
  logic [1:0] io_select;
  logic       io_mode;
  logic       io_freeze;
  logic [1:0] io_out,  io_out3;
  logic [1:0] io_cur_sel, io_cur_sel3;
  logic       io_switched, io_switched3;

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    string tag;
    int    due;
    int    kind;
    int    exp;
  } sb_t;
  sb_t sb_q[$];

  sw_mux_scanner #(.CH(4), .W(2), .DWELL(4), .DB_CYC(DB_CYC)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .io_in       (io_in),
    .io_select   (io_select),
    .io_mode     (io_mode),
    .io_freeze   (io_freeze),
    .io_out      (io_out),
    .io_cur_sel  (io_cur_sel),
    .io_switched (io_switched)
  );

  sw_mux_scanner #(.CH(3), .W(2), .DWELL(4), .DB_CYC(DB_CYC)) u_dut3 (
    .clock       (clock),
    .reset       (reset),
    .io_in       (io_in[5:0]),
    .io_select   (io_select),
    .io_mode     (io_mode),
    .io_freeze   (io_freeze),
    .io_out      (io_out3),
    .io_cur_sel  (io_cur_sel3),
    .io_switched (io_switched3)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic expect_at(input string tag, input int due, input int kind, input int exp);
    sb_q.push_back('{tag: tag, due: due, kind: kind, exp: exp});
  endtask

  function automatic int obs_of(input int kind);
    case (kind)
      K_OUT:   return int'(io_out);
      K_SEL:   return int'(io_cur_sel);
      K_SW:    return int'(io_switched);
      K_SEL3:  return int'(io_cur_sel3);
      default: return int'(io_switched3);
    endcase
  endfunction

  // Scoreboard monitor: falling edge, away from the active edge.
  always @(negedge clock) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cyc) begin
        check_val(sb_q[i].tag, obs_of(sb_q[i].kind), sb_q[i].exp);
        sb_q.delete(i);
      end else if (sb_q[i].due < cyc) begin
        check_val({sb_q[i].tag, "_missed"}, -1, sb_q[i].exp);
        sb_q.delete(i);
      end
    end
  end

  // Advance n rising edges and step just past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, e, r, s;
`ifdef SW_MUX_DEBOUNCE_EN
    int g, h;
`endif
    reset = 1'b1; io_in = 8'hE4; io_select = 2'd0; io_mode = 1'b0; io_freeze = 1'b0;
    tick(3);
    check_val("por_out", int'(io_out), 0);
    check_val("por_sel", int'(io_cur_sel), 0);
    check_val("por_sw",  int'(io_switched), 0);
    reset = 1'b0;
    tick(3);

    // ---- manual select 0 -> 2 -------------------------------------------
    t = cyc; io_select = 2'd2;
    expect_at("man_sel_early", t + L - 1, K_SEL, 0);
    expect_at("man_sel",       t + L,     K_SEL, 2);
    expect_at("man_out_old",   t + L,     K_OUT, 0);
    expect_at("man_out_new",   t + L + 1, K_OUT, 2);
    expect_at("man_sw_early",  t + L,     K_SW,  0);
    expect_at("man_sw",        t + L + 1, K_SW,  1);
    expect_at("man_sw_end",    t + L + 2, K_SW,  0);
    tick(L + 3);

    // ---- scan from channel 3, DWELL=4 -----------------------------------
    io_select = 2'd3;
    tick(L + 3);
    e = cyc; io_mode = 1'b1;
    expect_at("scan_sel3_hold", e + 4,  K_SEL, 3);
    expect_at("scan_wrap",      e + 5,  K_SEL, 0);
    expect_at("scan_sel0_hold", e + 8,  K_SEL, 0);
    expect_at("scan_sel1",      e + 9,  K_SEL, 1);
    expect_at("scan_sel1_hold", e + 12, K_SEL, 1);
    expect_at("scan_sel2",      e + 13, K_SEL, 2);
    expect_at("scan_sw_a",      e + 6,  K_SW,  1);
    expect_at("scan_sw_a_end",  e + 7,  K_SW,  0);
    expect_at("scan_sw_b",      e + 10, K_SW,  1);
    expect_at("scan_sw_c",      e + 14, K_SW,  1);
    expect_at("scan_out0",      e + 6,  K_OUT, 0);
    expect_at("scan_out1",      e + 10, K_OUT, 1);
    expect_at("scan_out2",      e + 14, K_OUT, 2);
    tick(15);

    // ---- freeze at dwell cycle 2 for 10 cycles ---------------------------
    io_freeze = 1'b1;
    tick(2);
    io_in = 8'h1B;
    expect_at("hold_out_a", e + 18, K_OUT, 2);
    expect_at("hold_sel_a", e + 18, K_SEL, 2);
    expect_at("hold_sw",    e + 20, K_SW,  0);
    expect_at("hold_out_b", e + 22, K_OUT, 2);
    expect_at("hold_out_c", e + 25, K_OUT, 2);
    expect_at("hold_sel_c", e + 25, K_SEL, 2);
    tick(8);
    io_freeze = 1'b0;
    expect_at("resume_out",       e + 27, K_OUT, 1);
    expect_at("resume_full_dwell", e + 29, K_SEL, 2);
    expect_at("resume_adv",       e + 30, K_SEL, 3);
    expect_at("resume_sw",        e + 31, K_SW,  1);
    tick(6);
    io_in = 8'hE4;
    expect_at("pre_rst_out", e + 32, K_OUT, 3);
    tick(1);

    // ---- asynchronous reset mid-scan --------------------------------------
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_out", int'(io_out), 0);
    check_val("arst_sel", int'(io_cur_sel), 0);
    check_val("arst_sw",  int'(io_switched), 0);
    io_mode = 1'b0; io_select = 2'd0;
    tick(1);
    reset = 1'b0;
    r = cyc;
    expect_at("post_rst_out",  r + 2, K_OUT, 0);
    expect_at("post_rst_sw",   r + 2, K_SW,  0);
    expect_at("post_rst_sw_b", r + 5, K_SW,  0);
    expect_at("post_rst_sel",  r + 6, K_SEL, 0);
    expect_at("post_rst_out_b", r + 6, K_OUT, 0);
    tick(7);

    // ---- CH=3 instance: out-of-range select ------------------------------
    io_select = 2'd1;
    tick(L + 3);
    s = cyc; io_select = 2'd3;
    expect_at("ch3_sel_pre", s,         K_SEL3, 1);
    expect_at("ch3_sel_keep", s + L,    K_SEL3, 1);
    expect_at("ch3_sel_keep_b", s + L + 2, K_SEL3, 1);
    expect_at("ch3_no_sw",   s + L + 1, K_SW3,  0);
    expect_at("ch3_no_sw_b", s + L + 2, K_SW3,  0);
    expect_at("ch4_sel3",    s + L,     K_SEL,  3);
    expect_at("ch4_sw",      s + L + 1, K_SW,   1);
    tick(L + 4);

`ifdef SW_MUX_DEBOUNCE_EN
    // ---- debounce: 2-cycle glitch ignored, 3-cycle pulse adopted ---------
    io_select = 2'd0;
    tick(8);
    g = cyc; io_select = 2'd1;
    expect_at("db_glitch_sel",   g + 5, K_SEL, 0);
    expect_at("db_glitch_sel_b", g + 7, K_SEL, 0);
    expect_at("db_glitch_sw",    g + 6, K_SW,  0);
    tick(2);
    io_select = 2'd0;
    tick(8);
    h = cyc; io_select = 2'd1;
    expect_at("db_adopt_early", h + 4,          K_SEL, 0);
    expect_at("db_adopt_sel",   h + DB_CYC + 2, K_SEL, 1);
    expect_at("db_adopt_sw",    h + DB_CYC + 3, K_SW,  1);
    tick(3);
    io_select = 2'd0;
    tick(6);
`endif

    tick(2);
    check_val("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
